// File: rtl/nms_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : nms_window_gen_if
// Description : Pixel-in / window-out handshake bundle for nms_window_gen.
// Revision    : 1.0
// ============================================================================
interface nms_window_gen_if #(
    parameter int MAG_W = 11,
    parameter int DIR_W = 2
);
    logic [MAG_W-1:0]   pix_mag;
    logic [DIR_W-1:0]   pix_dir;
    logic               pix_valid;
    logic               pix_ready;
    logic [9*MAG_W-1:0] mag_window;
    logic [9*DIR_W-1:0] dir_window;
    logic               mag_window_valid;
    logic               dir_window_valid;
    logic               win_ready;
    logic               win_last;

    // Environment side: supplies pixels and consumes windows
    modport master (
        output pix_mag, pix_dir, pix_valid, win_ready,
        input  pix_ready, mag_window, dir_window,
               mag_window_valid, dir_window_valid, win_last
    );

    // Window generator side
    modport slave (
        input  pix_mag, pix_dir, pix_valid, win_ready,
        output pix_ready, mag_window, dir_window,
               mag_window_valid, dir_window_valid, win_last
    );
endinterface
`default_nettype wire

// File: rtl/nms_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : nms_window_gen
// Description : Two-line-buffer 3x3 magnitude/direction window builder for NMS.
// Revision    : 1.0
// ============================================================================
module nms_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MAG_W      = 11,
    parameter int DIR_W      = 2
) (
    input wire logic         clk,
    input wire logic         reset,
    nms_window_gen_if.slave  bus
);
    localparam int c_COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;

    logic [MAG_W-1:0] r_lb_top_mag [IMG_WIDTH];
    logic [MAG_W-1:0] r_lb_mid_mag [IMG_WIDTH];
    logic [DIR_W-1:0] r_lb_top_dir [IMG_WIDTH];
    logic [DIR_W-1:0] r_lb_mid_dir [IMG_WIDTH];

    logic [MAG_W-1:0] r_win_mag [9];
    logic [DIR_W-1:0] r_win_dir [9];
    logic [MAG_W-1:0] w_next_mag [9];
    logic [DIR_W-1:0] w_next_dir [9];

    logic [9*MAG_W-1:0] w_pack_mag;
    logic [9*DIR_W-1:0] w_pack_dir;
    logic [9*MAG_W-1:0] r_mag_window;
    logic [9*DIR_W-1:0] r_dir_window;
    logic               r_valid;
    logic               r_last;

    logic w_ready;
    logic w_xfer;
    logic w_col_wrap;
    logic w_emit;
    logic w_frame_last;

    assign w_ready      = !r_valid || bus.win_ready;
    assign w_xfer       = bus.pix_valid && w_ready;
    assign w_col_wrap   = (r_col == c_COL_LAST);
    assign w_emit       = w_xfer && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
    assign w_frame_last = (r_row == c_ROW_LAST) && w_col_wrap;

    // Raster position of the pixel currently being offered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_xfer) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Window shifts left; new right column is (lb_top, lb_mid, incoming)
    always_comb begin
        w_next_mag[0] = r_win_mag[1];
        w_next_mag[1] = r_win_mag[2];
        w_next_mag[2] = r_lb_top_mag[r_col];
        w_next_mag[3] = r_win_mag[4];
        w_next_mag[4] = r_win_mag[5];
        w_next_mag[5] = r_lb_mid_mag[r_col];
        w_next_mag[6] = r_win_mag[7];
        w_next_mag[7] = r_win_mag[8];
        w_next_mag[8] = bus.pix_mag;

        w_next_dir[0] = r_win_dir[1];
        w_next_dir[1] = r_win_dir[2];
        w_next_dir[2] = r_lb_top_dir[r_col];
        w_next_dir[3] = r_win_dir[4];
        w_next_dir[4] = r_win_dir[5];
        w_next_dir[5] = r_lb_mid_dir[r_col];
        w_next_dir[6] = r_win_dir[7];
        w_next_dir[7] = r_win_dir[8];
        w_next_dir[8] = bus.pix_dir;
    end

    generate
        for (genvar n = 0; n < 9; n++) begin : g_pack
            assign w_pack_mag[n*MAG_W +: MAG_W] = w_next_mag[n];
            assign w_pack_dir[n*DIR_W +: DIR_W] = w_next_dir[n];
        end
    endgenerate

    // Line buffers and shift window need no reset: rows 0-1 refill them
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_lb_top_mag[r_col] <= r_lb_mid_mag[r_col];
            r_lb_mid_mag[r_col] <= bus.pix_mag;
            r_lb_top_dir[r_col] <= r_lb_mid_dir[r_col];
            r_lb_mid_dir[r_col] <= bus.pix_dir;
            for (int n = 0; n < 9; n++) begin
                r_win_mag[n] <= w_next_mag[n];
                r_win_dir[n] <= w_next_dir[n];
            end
        end
    end

    // Registered output window; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag_window <= '0;
            r_dir_window <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
        end else if (w_emit) begin
            r_mag_window <= w_pack_mag;
            r_dir_window <= w_pack_dir;
            r_valid      <= 1'b1;
            r_last       <= w_frame_last;
        end else if (bus.win_ready) begin
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
        end
    end

    assign bus.pix_ready        = w_ready;
    assign bus.mag_window       = r_mag_window;
    assign bus.dir_window       = r_dir_window;
    assign bus.mag_window_valid = r_valid;
    assign bus.dir_window_valid = r_valid;
    assign bus.win_last         = r_last;

endmodule
`default_nettype wire

// File: tb/tb_nms_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nms_window_gen
// Description : Directed self-checking bench for nms_window_gen (W=5, H=4).
// Revision    : 1.0
// ============================================================================
module tb_nms_window_gen;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int MW = 11;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nms_window_gen_if #(.MAG_W(MW), .DIR_W(DW)) bus ();

    nms_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .MAG_W     (MW),
        .DIR_W     (DW)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [9*MW-1:0] mag;
        logic [9*DW-1:0] dir;
        logic            last;
    } win_t;

    int        checks     = 0;
    int        failures   = 0;
    win_t      q[$];
    int        dir_mode   = 0;
    bit        stall_en   = 1'b0;
    int        stall_done = 0;
    logic      prev_stalled = 1'b0;
    logic [9*MW-1:0] prev_mag;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pdir(input int r, input int c);
        return (dir_mode != 0) ? ((r + c) & 3) : (c & 3);
    endfunction

    function automatic logic [9*MW-1:0] exp_mag(input int rc, input int cc);
        logic [9*MW-1:0] m;
        m = '0;
        for (int n = 0; n < 9; n++)
            m[n*MW +: MW] = MW'(16 * (rc - 1 + n / 3) + (cc - 1 + n % 3));
        return m;
    endfunction

    function automatic logic [9*DW-1:0] exp_dir(input int rc, input int cc);
        logic [9*DW-1:0] d;
        d = '0;
        for (int n = 0; n < 9; n++)
            d[n*DW +: DW] = DW'(pdir(rc - 1 + n / 3, cc - 1 + n % 3));
        return d;
    endfunction

    // Consumer: controls win_ready, captures taken windows, checks stall hold
    always @(negedge clk) begin
        if (stall_en && bus.mag_window_valid && q.size() == 1 && stall_done < 3) begin
            bus.win_ready = 1'b0;
            stall_done++;
        end else begin
            bus.win_ready = 1'b1;
        end
        #2;
        chk("valid_pair", {127'd0, bus.dir_window_valid}, {127'd0, bus.mag_window_valid});
        if (prev_stalled) begin
            chk("hold_mag", {29'd0, bus.mag_window}, {29'd0, prev_mag});
            chk("hold_valid", {127'd0, bus.mag_window_valid}, 128'd1);
        end
        if (bus.mag_window_valid && !bus.win_ready)
            chk("stall_pix_ready", {127'd0, bus.pix_ready}, 128'd0);
        prev_stalled = bus.mag_window_valid && !bus.win_ready && !rst;
        prev_mag     = bus.mag_window;
        if (bus.mag_window_valid && bus.win_ready && !rst)
            q.push_back('{mag: bus.mag_window, dir: bus.dir_window, last: bus.win_last});
    end

    task automatic push(input int r, input int c, input bit gap);
        bit ok;
        ok = 1'b0;
        if (gap && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
        end
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_mag   = MW'(16 * r + c);
        bus.pix_dir   = DW'(pdir(r, c));
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus.pix_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk($sformatf("push_timeout_r%0d_c%0d", r, c), 128'd0, 128'd1);
        else     @(posedge clk);
    endtask

    task automatic push_frame(input bit gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                push(r, c, gap);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.pix_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_windows(input int nwin, input string tag);
        chk({tag, "_count"}, 128'(q.size()), 128'(nwin));
        for (int i = 0; i < q.size() && i < nwin; i++) begin
            int idx, rc, cc;
            idx = i % 6;
            rc  = 1 + idx / 3;
            cc  = 1 + idx % 3;
            chk($sformatf("%s_mag%0d", tag, i), {29'd0, q[i].mag}, {29'd0, exp_mag(rc, cc)});
            chk($sformatf("%s_dir%0d", tag, i), {110'd0, q[i].dir}, {110'd0, exp_dir(rc, cc)});
            chk($sformatf("%s_ctr_dir%0d", tag, i), {126'd0, q[i].dir[9:8]}, 128'(pdir(rc, cc)));
            chk($sformatf("%s_last%0d", tag, i), {127'd0, q[i].last}, {127'd0, (idx == 5)});
        end
        q.delete();
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_mag   = '0;
        bus.pix_dir   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #3;
        chk("rst_mag",   {29'd0, bus.mag_window}, 128'd0);
        chk("rst_dir",   {110'd0, bus.dir_window}, 128'd0);
        chk("rst_valid", {127'd0, bus.mag_window_valid}, 128'd0);
        chk("rst_dvalid", {127'd0, bus.dir_window_valid}, 128'd0);
        chk("rst_last",  {127'd0, bus.win_last}, 128'd0);
        rst = 1'b0;

        // Frame 1 with latency and element-position checks
        dir_mode = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                push(r, c, 1'b0);
                if (r == 2 && c == 1) begin
                    #1;
                    chk("lat_pre_valid", {127'd0, bus.mag_window_valid}, 128'd0);
                end
                if (r == 2 && c == 2) begin
                    #1;
                    chk("lat_valid", {127'd0, bus.mag_window_valid}, 128'd1);
                    chk("first_n4", 128'(bus.mag_window[54:44]), 128'd17);
                    chk("first_n0", 128'(bus.mag_window[10:0]),  128'd0);
                    chk("first_n8", 128'(bus.mag_window[98:88]), 128'd34);
                    chk("first_n3", 128'(bus.mag_window[43:33]), 128'd16);
                    chk("first_n5", 128'(bus.mag_window[65:55]), 128'd18);
                end
            end
        end
        idle();
        check_windows(6, "f1");

        // Consumer stall on the second window
        stall_done = 0;
        stall_en   = 1'b1;
        push_frame(1'b0);
        idle();
        stall_en = 1'b0;
        chk("stall_cycles", 128'(stall_done), 128'd3);
        check_windows(6, "stall");

        // Two frames back-to-back, diagonal direction pattern
        dir_mode = 1;
        push_frame(1'b0);
        push_frame(1'b0);
        idle();
        check_windows(12, "b2b");

        // Random input gaps
        dir_mode = 0;
        push_frame(1'b1);
        idle();
        check_windows(6, "gaps");

        // Reset in the middle of a frame, offered pixel (2,3) is dropped
        dir_mode = 1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (!(r == 2 && c > 2)) push(r, c, 1'b0);
        @(negedge clk);
        rst           = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_mag   = MW'(16 * 2 + 3);
        bus.pix_dir   = DW'(pdir(2, 3));
        @(negedge clk);
        #3;
        chk("mid_rst_mag",   {29'd0, bus.mag_window}, 128'd0);
        chk("mid_rst_dir",   {110'd0, bus.dir_window}, 128'd0);
        chk("mid_rst_valid", {127'd0, bus.mag_window_valid}, 128'd0);
        chk("mid_rst_last",  {127'd0, bus.win_last}, 128'd0);
        rst           = 1'b0;
        bus.pix_valid = 1'b0;
        q.delete();
        push_frame(1'b0);
        idle();
        check_windows(6, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
